// File: rtl/apb_master_arbiter.sv
// Two-requester round-robin arbiter driving a single APB4 master port.
// Runs SETUP/ACCESS per grant, returns rdata/err with a done pulse, aborts hung transfers on timeout.
module apb_master_arbiter #(
   parameter int unsigned ADDR_W         = 32,
   parameter int unsigned DATA_W         = 32,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic              pclk,
   input  logic              preset_n,
   input  logic              r0_req,
   input  logic [ADDR_W-1:0] r0_addr,
   input  logic              r0_write,
   input  logic [DATA_W-1:0] r0_wdata,
   input  logic [3:0]        r0_strb,
   output logic              r0_done,
   output logic [DATA_W-1:0] r0_rdata,
   output logic              r0_err,
   input  logic              r1_req,
   input  logic [ADDR_W-1:0] r1_addr,
   input  logic              r1_write,
   input  logic [DATA_W-1:0] r1_wdata,
   input  logic [3:0]        r1_strb,
   output logic              r1_done,
   output logic [DATA_W-1:0] r1_rdata,
   output logic              r1_err,
   output logic [ADDR_W-1:0] m_paddr,
   output logic              m_psel,
   output logic              m_penable,
   output logic              m_pwrite,
   output logic [DATA_W-1:0] m_pwdata,
   output logic [3:0]        m_pstrb,
   input  logic              m_pready,
   input  logic [DATA_W-1:0] m_prdata,
   input  logic              m_pslverr,
   output logic              owner,
   output logic              busy
);

   localparam int unsigned STRB_W = 4;
   localparam int unsigned CNT_W  = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);
   localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETUP  = 2'd1,
      S_ACCESS = 2'd2
   } state_t;

   state_t              r_state, w_state_nxt;
   logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
   logic                r_last_grant, w_last_grant_nxt;
   logic                r_owner, w_owner_nxt;
   logic                r_busy, w_busy_nxt;
   logic [ADDR_W-1:0]   r_paddr, w_paddr_nxt;
   logic                r_psel, w_psel_nxt;
   logic                r_penable, w_penable_nxt;
   logic                r_pwrite, w_pwrite_nxt;
   logic [DATA_W-1:0]   r_pwdata, w_pwdata_nxt;
   logic [STRB_W-1:0]   r_pstrb, w_pstrb_nxt;
   logic                r_done0, w_done0_nxt;
   logic                r_done1, w_done1_nxt;
   logic [DATA_W-1:0]   r_rdata0, w_rdata0_nxt;
   logic [DATA_W-1:0]   r_rdata1, w_rdata1_nxt;
   logic                r_err0, w_err0_nxt;
   logic                r_err1, w_err1_nxt;

   logic                w_req0, w_req1, w_win, w_timeout, w_finish;
   logic [DATA_W-1:0]   w_fin_rdata;
   logic                w_fin_err;

   // A requester seeing its done pulse this cycle is not re-granted on a stale req
   assign w_req0      = r0_req & ~r_done0;
   assign w_req1      = r1_req & ~r_done1;
   assign w_win       = (w_req0 && w_req1) ? ~r_last_grant : w_req1;
   assign w_timeout   = TIMEOUT_EN && (r_cnt == CNT_LIMIT);
   assign w_finish    = m_pready || w_timeout;
   assign w_fin_rdata = m_pready ? m_prdata : '0;
   assign w_fin_err   = m_pready ? m_pslverr : 1'b1;

   // Next-state and next-output logic
   always_comb begin
      w_state_nxt      = r_state;
      w_cnt_nxt        = r_cnt;
      w_last_grant_nxt = r_last_grant;
      w_owner_nxt      = r_owner;
      w_busy_nxt       = r_busy;
      w_paddr_nxt      = r_paddr;
      w_psel_nxt       = r_psel;
      w_penable_nxt    = r_penable;
      w_pwrite_nxt     = r_pwrite;
      w_pwdata_nxt     = r_pwdata;
      w_pstrb_nxt      = r_pstrb;
      w_done0_nxt      = 1'b0;
      w_done1_nxt      = 1'b0;
      w_rdata0_nxt     = r_rdata0;
      w_rdata1_nxt     = r_rdata1;
      w_err0_nxt       = r_err0;
      w_err1_nxt       = r_err1;

      case (r_state)
         S_IDLE: begin
            if (w_req0 || w_req1) begin
               w_paddr_nxt      = w_win ? r1_addr  : r0_addr;
               w_pwrite_nxt     = w_win ? r1_write : r0_write;
               w_pwdata_nxt     = w_win ? r1_wdata : r0_wdata;
               w_pstrb_nxt      = w_win ? r1_strb  : r0_strb;
               w_owner_nxt      = w_win;
               w_last_grant_nxt = w_win;
               w_psel_nxt       = 1'b1;
               w_busy_nxt       = 1'b1;
               w_state_nxt      = S_SETUP;
            end
         end
         S_SETUP: begin
            w_penable_nxt = 1'b1;
            w_cnt_nxt     = CNT_W'(1);
            w_state_nxt   = S_ACCESS;
         end
         S_ACCESS: begin
            // A ready response on the limit cycle completes normally
            if (w_finish) begin
               w_psel_nxt    = 1'b0;
               w_penable_nxt = 1'b0;
               w_busy_nxt    = 1'b0;
               w_state_nxt   = S_IDLE;
               if (r_owner) begin
                  w_done1_nxt  = 1'b1;
                  w_rdata1_nxt = w_fin_rdata;
                  w_err1_nxt   = w_fin_err;
               end else begin
                  w_done0_nxt  = 1'b1;
                  w_rdata0_nxt = w_fin_rdata;
                  w_err0_nxt   = w_fin_err;
               end
            end else if (TIMEOUT_EN) begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // State and registered outputs
   always_ff @(posedge pclk or negedge preset_n) begin
      if (!preset_n) begin
         r_state      <= S_IDLE;
         r_cnt        <= '0;
         r_last_grant <= 1'b1;
         r_owner      <= 1'b0;
         r_busy       <= 1'b0;
         r_paddr      <= '0;
         r_psel       <= 1'b0;
         r_penable    <= 1'b0;
         r_pwrite     <= 1'b0;
         r_pwdata     <= '0;
         r_pstrb      <= '0;
         r_done0      <= 1'b0;
         r_done1      <= 1'b0;
         r_rdata0     <= '0;
         r_rdata1     <= '0;
         r_err0       <= 1'b0;
         r_err1       <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_cnt        <= w_cnt_nxt;
         r_last_grant <= w_last_grant_nxt;
         r_owner      <= w_owner_nxt;
         r_busy       <= w_busy_nxt;
         r_paddr      <= w_paddr_nxt;
         r_psel       <= w_psel_nxt;
         r_penable    <= w_penable_nxt;
         r_pwrite     <= w_pwrite_nxt;
         r_pwdata     <= w_pwdata_nxt;
         r_pstrb      <= w_pstrb_nxt;
         r_done0      <= w_done0_nxt;
         r_done1      <= w_done1_nxt;
         r_rdata0     <= w_rdata0_nxt;
         r_rdata1     <= w_rdata1_nxt;
         r_err0       <= w_err0_nxt;
         r_err1       <= w_err1_nxt;
      end
   end

   assign m_paddr   = r_paddr;
   assign m_psel    = r_psel;
   assign m_penable = r_penable;
   assign m_pwrite  = r_pwrite;
   assign m_pwdata  = r_pwdata;
   assign m_pstrb   = r_pstrb;
   assign owner     = r_owner;
   assign busy      = r_busy;
   assign r0_done   = r_done0;
   assign r0_rdata  = r_rdata0;
   assign r0_err    = r_err0;
   assign r1_done   = r_done1;
   assign r1_rdata  = r_rdata1;
   assign r1_err    = r_err1;

endmodule
